id_ex_skid_stage: RTL and testbench

Parametrised, elastic successor to the fixed ID→EX pipeline register. It carries an opaque decode payload plus a delay-slot flag, with valid/ready handshakes on both sides. A 2-entry skid buffer provides full throughput under downstream backpressure. It also supports synchronous flush, NOP (bubble) insertion, occupancy reporting and a saturating stall-cycle counter. It sits between the ID and EX stages and is reusable for any other stage boundary.

---
 rtl/id_ex_skid_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_skid_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_stage
// Brief    : Elastic ID->EX stage with a 2-entry skid buffer, flush, bubble
//            output, occupancy and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_skid_stage #(
    parameter int                      PAYLOAD_W   = 128,
    parameter logic [PAYLOAD_W-1:0]    NOP_PAYLOAD = {PAYLOAD_W{1'b0}},
    parameter int                      CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic                  in_delayslot,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic                  out_delayslot,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] c_stall_max = {CNT_W{1'b1}};

    logic                 r_main_valid;
    logic [PAYLOAD_W-1:0] r_main_payload;
    logic                 r_main_ds;
    logic                 r_skid_valid;
    logic [PAYLOAD_W-1:0] r_skid_payload;
    logic                 r_skid_ds;
    logic [1:0]           r_occupancy;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic                 w_accept;
    logic                 w_drain;
    logic                 w_nxt_main_valid;
    logic [PAYLOAD_W-1:0] w_nxt_main_payload;
    logic                 w_nxt_main_ds;
    logic                 w_nxt_skid_valid;
    logic [PAYLOAD_W-1:0] w_nxt_skid_payload;
    logic                 w_nxt_skid_ds;

    // Ready depends only on registered skid state, never on out_ready.
    assign in_ready      = !r_skid_valid && !rst;
    assign w_accept      = in_valid && in_ready;
    assign w_drain       = r_main_valid && out_ready;

    assign out_valid     = r_main_valid;
    assign out_payload   = r_main_payload;
    assign out_delayslot = r_main_ds;
    assign occupancy     = r_occupancy;
    assign stall_cycles  = r_stall_cnt;

    always_comb begin
        w_nxt_main_valid   = r_main_valid;
        w_nxt_main_payload = r_main_payload;
        w_nxt_main_ds      = r_main_ds;
        w_nxt_skid_valid   = r_skid_valid;
        w_nxt_skid_payload = r_skid_payload;
        w_nxt_skid_ds      = r_skid_ds;

        if (flush) begin
            w_nxt_main_valid   = 1'b0;
            w_nxt_main_payload = NOP_PAYLOAD;
            w_nxt_main_ds      = 1'b0;
            w_nxt_skid_valid   = 1'b0;
        end else if (r_skid_valid) begin
            if (w_drain) begin
                w_nxt_main_valid   = 1'b1;
                w_nxt_main_payload = r_skid_payload;
                w_nxt_main_ds      = r_skid_ds;
                w_nxt_skid_valid   = 1'b0;
            end
        end else if (w_accept && (!r_main_valid || w_drain)) begin
            w_nxt_main_valid   = 1'b1;
            w_nxt_main_payload = in_payload;
            w_nxt_main_ds      = in_delayslot;
        end else if (w_accept) begin
            w_nxt_skid_valid   = 1'b1;
            w_nxt_skid_payload = in_payload;
            w_nxt_skid_ds      = in_delayslot;
        end else if (w_drain) begin
            // Going empty: park the bubble so the outputs read as NOP.
            w_nxt_main_valid   = 1'b0;
            w_nxt_main_payload = NOP_PAYLOAD;
            w_nxt_main_ds      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid   <= 1'b0;
            r_main_payload <= NOP_PAYLOAD;
            r_main_ds      <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_payload <= NOP_PAYLOAD;
            r_skid_ds      <= 1'b0;
            r_occupancy    <= 2'd0;
        end else begin
            r_main_valid   <= w_nxt_main_valid;
            r_main_payload <= w_nxt_main_payload;
            r_main_ds      <= w_nxt_main_ds;
            r_skid_valid   <= w_nxt_skid_valid;
            r_skid_payload <= w_nxt_skid_payload;
            r_skid_ds      <= w_nxt_skid_ds;
            r_occupancy    <= {1'b0, w_nxt_main_valid} + {1'b0, w_nxt_skid_valid};
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_skid_stage
// Brief    : Directed self-checking bench for id_ex_skid_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_skid_stage;

    localparam int                PAYLOAD_W = 128;
    localparam int                CNT_W     = 4;
    localparam logic [127:0]      c_nop     = 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0013;
    localparam logic [127:0]      c_aa      = {16{8'hAA}};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_delayslot;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_delayslot;
    logic [1:0]           occupancy;
    logic [CNT_W-1:0]     stall_cycles;

    int n_total  = 0;
    int n_passed = 0;

    id_ex_skid_stage #(
        .PAYLOAD_W   (PAYLOAD_W),
        .NOP_PAYLOAD (c_nop),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_payload    (in_payload),
        .in_delayslot  (in_delayslot),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_payload   (out_payload),
        .out_delayslot (out_delayslot),
        .occupancy     (occupancy),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, " out_valid"}, 128'(out_valid), 128'(0));
        check({tag, " out_payload"}, out_payload, c_nop);
        check({tag, " out_delayslot"}, 128'(out_delayslot), 128'(0));
        check({tag, " occupancy"}, 128'(occupancy), 128'(0));
    endtask

    initial begin
        // Reset with an offered entry that must be ignored
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_payload = c_aa;
        in_delayslot = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        check_empty("reset");
        check("reset in_ready", 128'(in_ready), 128'(0));
        check("reset stall", 128'(stall_cycles), 128'(0));
        rst = 1'b0; in_valid = 1'b0; in_delayslot = 1'b0;
        #1;
        check("post-reset in_ready", 128'(in_ready), 128'(1));

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_payload = 128'(i);
            tick();
            check("stream payload", out_payload, 128'(i));
            check("stream valid", 128'(out_valid), 128'(1));
            check("stream occupancy", 128'(occupancy), 128'(1));
        end
        in_valid = 1'b0;
        tick();
        check_empty("stream drained");
        check("stream stall", 128'(stall_cycles), 128'(0));

        // Backpressure into skid
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 128'h5;
        tick();
        check("bp first payload", out_payload, 128'h5);
        check("bp first in_ready", 128'(in_ready), 128'(1));
        in_payload = 128'h6;
        tick();
        check("bp full in_ready", 128'(in_ready), 128'(0));
        check("bp full occupancy", 128'(occupancy), 128'(2));
        check("bp full payload", out_payload, 128'h5);
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("bp hold payload", out_payload, 128'h5);
        check("bp hold stall", 128'(stall_cycles), 128'(4));
        out_ready = 1'b1;
        tick();
        check("bp drain payload", out_payload, 128'h6);
        check("bp drain occupancy", 128'(occupancy), 128'(1));
        check("bp drain in_ready", 128'(in_ready), 128'(1));
        check("bp drain stall", 128'(stall_cycles), 128'(4));
        tick();
        check_empty("bp empty");

        // Flush while full with input offered
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 128'h8;
        tick();
        in_payload = 128'h9;
        tick();
        check("flush pre occupancy", 128'(occupancy), 128'(2));
        flush = 1'b1; in_payload = 128'h7;
        tick();
        check_empty("flush full");
        check("flush full in_ready", 128'(in_ready), 128'(1));
        check("flush keeps stall", 128'(stall_cycles), 128'(6));
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush no 7", 128'(out_valid), 128'(0));

        // Flush with main only, input is acceptable but must be dropped
        in_valid = 1'b1; in_payload = 128'hA;
        tick();
        flush = 1'b1; in_payload = 128'h7;
        tick();
        check_empty("flush main");
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush main no 7", 128'(out_valid), 128'(0));
        check("flush main stall", 128'(stall_cycles), 128'(7));

        // Delay-slot alignment
        out_ready = 1'b1; in_valid = 1'b1; in_payload = 128'h100; in_delayslot = 1'b0;
        tick();
        check("ds branch payload", out_payload, 128'h100);
        check("ds branch flag", 128'(out_delayslot), 128'(0));
        in_payload = 128'h101; in_delayslot = 1'b1;
        tick();
        check("ds slot payload", out_payload, 128'h101);
        check("ds slot flag", 128'(out_delayslot), 128'(1));
        in_valid = 1'b0;
        tick();
        check_empty("ds idle");

        // Counter saturation (7 already counted)
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 128'h55; in_delayslot = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("sat 14", 128'(stall_cycles), 128'(14));
        tick();
        check("sat 15", 128'(stall_cycles), 128'(15));
        for (int i = 0; i < 12; i++) tick();
        check("sat hold", 128'(stall_cycles), 128'(15));
        check("sat payload", out_payload, 128'h55);

        // Reset with an entry held
        rst = 1'b1;
        tick();
        check_empty("mid reset");
        check("mid reset stall", 128'(stall_cycles), 128'(0));
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
